// File: rtl/ssd_time_decoder.sv
// Samples six 7-segment digit buses, filters glitches, range-checks the time and
// converts it to binary seconds-of-day. Optional bcd_out port: SSD_TIME_DEC_BCD_OUT_EN.
`ifndef SSD_SEG_DEFINES
`define SSD_SEG_DEFINES
`define ZERO  7'h3F
`define ONE   7'h06
`define TWO   7'h5B
`define THREE 7'h4F
`define FOUR  7'h66
`define FIVE  7'h6D
`define SIX   7'h7D
`define SEVEN 7'h07
`define EIGHT 7'h7F
`define NINE  7'h6F
`endif

module ssd_time_decoder #(
   parameter int STABLE_CNT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sample_en,
   input  logic [6:0]  ssd_hour_h_in,
   input  logic [6:0]  ssd_hour_l_in,
   input  logic [6:0]  ssd_min_h_in,
   input  logic [6:0]  ssd_min_l_in,
   input  logic [6:0]  ssd_sec_h_in,
   input  logic [6:0]  ssd_sec_l_in,
   input  logic        sod_ready,
   output logic        sod_valid,
   output logic [16:0] sod_out,
   output logic        day_wrap,
   output logic        pattern_err
`ifdef SSD_TIME_DEC_BCD_OUT_EN
   ,
   output logic [23:0] bcd_out
`endif
);

   // Handshake: a result transfers on any clk edge where sod_valid && sod_ready;
   // sod_valid never drops, and sod_out/day_wrap never change, before that edge.

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_CALC_H, S_CALC_M, S_CALC_S, S_OUT
   } state_t;

   localparam logic [3:0]  STABLE_C = 4'(STABLE_CNT);
   localparam logic [16:0] SOD_MAX  = 17'd86399;

   state_t      state_q, state_d;
   logic [41:0] cap_q, cap_d;
   logic [41:0] last_q, last_d;
   logic        last_vld_q, last_vld_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [23:0] dig_q, dig_d;
   logic [16:0] acc_q, acc_d;
   logic [16:0] sod_q, sod_d;
   logic [16:0] prev_q, prev_d;
   logic        wrap_q, wrap_d;
   logic        err_q, err_d;
`ifdef SSD_TIME_DEC_BCD_OUT_EN
   logic [23:0] bcd_q, bcd_d;
`endif

   logic [41:0] cap_in;
   logic [3:0]  cnt_nxt;
   logic        accept;
   logic [23:0] dec_dig;
   logic        dec_ok;
   logic [4:0]  dec_r;
   logic [16:0] acc_s;

   function automatic logic [4:0] dec7(input logic [6:0] p);
      case (p)
         `ZERO:   dec7 = {1'b1, 4'd0};
         `ONE:    dec7 = {1'b1, 4'd1};
         `TWO:    dec7 = {1'b1, 4'd2};
         `THREE:  dec7 = {1'b1, 4'd3};
         `FOUR:   dec7 = {1'b1, 4'd4};
         `FIVE:   dec7 = {1'b1, 4'd5};
         `SIX:    dec7 = {1'b1, 4'd6};
         `SEVEN:  dec7 = {1'b1, 4'd7};
         `EIGHT:  dec7 = {1'b1, 4'd8};
         `NINE:   dec7 = {1'b1, 4'd9};
         default: dec7 = 5'd0;
      endcase
   endfunction

   function automatic logic [16:0] tens(input logic [3:0] hi, input logic [3:0] lo);
      tens = 17'(hi) * 17'd10 + 17'(lo);
   endfunction

   // Glitch filter: counter tracks how many consecutive strobes saw this capture.
   always_comb begin
      cap_in = {ssd_hour_h_in, ssd_hour_l_in, ssd_min_h_in,
                ssd_min_l_in, ssd_sec_h_in, ssd_sec_l_in};
      if (cap_in != cap_q)
         cnt_nxt = 4'd1;
      else if (cnt_q >= STABLE_C)
         cnt_nxt = STABLE_C;
      else
         cnt_nxt = cnt_q + 4'd1;
      accept = (cnt_nxt == STABLE_C) && (!last_vld_q || (cap_in != last_q));
   end

   always_comb begin
      dec_ok  = 1'b1;
      dec_dig = '0;
      dec_r   = '0;
      for (int i = 0; i < 6; i++) begin
         dec_r               = dec7(cap_q[i*7 +: 7]);
         dec_dig[i*4 +: 4]   = dec_r[3:0];
         dec_ok              = dec_ok & dec_r[4];
      end
      if ((dec_dig[23:20] > 4'd2) || (dec_dig[15:12] > 4'd5) || (dec_dig[7:4] > 4'd5) ||
          ((dec_dig[23:20] == 4'd2) && (dec_dig[19:16] > 4'd3)))
         dec_ok = 1'b0;
   end

   assign acc_s = acc_q * 17'd60 + tens(dig_q[7:4], dig_q[3:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (sample_en && accept) state_d = S_DECODE;
         S_DECODE: state_d = dec_ok ? S_CALC_H : S_IDLE;
         S_CALC_H: state_d = S_CALC_M;
         S_CALC_M: state_d = S_CALC_S;
         S_CALC_S: state_d = S_OUT;
         S_OUT:    if (sod_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sod_valid   = (state_q == S_OUT);
      sod_out     = sod_q;
      day_wrap    = sod_valid & wrap_q;
      pattern_err = err_q;
   end

   always_comb begin
      cap_d      = cap_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      last_vld_d = last_vld_q;
      dig_d      = dig_q;
      acc_d      = acc_q;
      sod_d      = sod_q;
      prev_d     = prev_q;
      wrap_d     = wrap_q;
      err_d      = 1'b0;
`ifdef SSD_TIME_DEC_BCD_OUT_EN
      bcd_d      = bcd_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (sample_en) begin
               cap_d = cap_in;
               cnt_d = cnt_nxt;
            end
         end
         S_DECODE: begin
            dig_d = dec_dig;
            // Remember a bad value too, so holding it does not pulse again.
            if (!dec_ok) begin
               err_d      = 1'b1;
               last_d     = cap_q;
               last_vld_d = 1'b1;
            end
         end
         S_CALC_H: acc_d = tens(dig_q[23:20], dig_q[19:16]);
         S_CALC_M: acc_d = acc_q * 17'd60 + tens(dig_q[15:12], dig_q[11:8]);
         S_CALC_S: begin
            sod_d      = acc_s;
            wrap_d     = (acc_s == 17'd0) && (prev_q == SOD_MAX);
            prev_d     = acc_s;
            last_d     = cap_q;
            last_vld_d = 1'b1;
`ifdef SSD_TIME_DEC_BCD_OUT_EN
            bcd_d      = dig_q;
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_q      <= '0;
         cnt_q      <= '0;
         last_q     <= '0;
         last_vld_q <= 1'b0;
         dig_q      <= '0;
         acc_q      <= '0;
         sod_q      <= '0;
         prev_q     <= '0;
         wrap_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         cap_q      <= cap_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         last_vld_q <= last_vld_d;
         dig_q      <= dig_d;
         acc_q      <= acc_d;
         sod_q      <= sod_d;
         prev_q     <= prev_d;
         wrap_q     <= wrap_d;
         err_q      <= err_d;
      end
   end

`ifdef SSD_TIME_DEC_BCD_OUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bcd_q <= '0;
      else        bcd_q <= bcd_d;
   end

   assign bcd_out = bcd_q;
`endif

endmodule

// File: tb/tb_ssd_time_decoder.sv
// Bench for ssd_time_decoder: directed scenarios plus randomized times checked
// against a seconds-of-day reference model.
module tb_ssd_time_decoder;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sample_en = 1'b0;
   logic        sod_ready = 1'b1;
   logic [6:0]  hh_in = '0, hl_in = '0, mh_in = '0, ml_in = '0, sh_in = '0, sl_in = '0;
   logic        sod_valid;
   logic [16:0] sod_out;
   logic        day_wrap;
   logic        pattern_err;
`ifdef SSD_TIME_DEC_BCD_OUT_EN
   logic [23:0] bcd_out;
`endif

   ssd_time_decoder #(.STABLE_CNT(S)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sample_en     (sample_en),
      .ssd_hour_h_in (hh_in),
      .ssd_hour_l_in (hl_in),
      .ssd_min_h_in  (mh_in),
      .ssd_min_l_in  (ml_in),
      .ssd_sec_h_in  (sh_in),
      .ssd_sec_l_in  (sl_in),
      .sod_ready     (sod_ready),
      .sod_valid     (sod_valid),
      .sod_out       (sod_out),
      .day_wrap      (day_wrap),
      .pattern_err   (pattern_err)
`ifdef SSD_TIME_DEC_BCD_OUT_EN
      ,
      .bcd_out       (bcd_out)
`endif
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- reference data and model ----------------
   logic [6:0] seg [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   int          n_vec = 0;
   int          n_err = 0;
   logic [16:0] exp_q[$];

   logic [41:0] m_cap;
   int          m_cnt;
   logic [41:0] m_last;
   bit          m_last_vld;
   int          m_prev;

   // results of the last hold() call: e_* expected, o_* observed
   int          e_err, e_conv, e_idx;
   logic        e_wrap;
   int          o_err, o_vcnt, o_vidx, o_vcyc, o_badwrap;
   logic [16:0] o_sod;
   logic        o_wrap;
   logic [23:0] o_bcd;

   function automatic logic [41:0] pat(input int h, input int m, input int s);
      pat = {seg[h/10], seg[h%10], seg[m/10], seg[m%10], seg[s/10], seg[s%10]};
   endfunction

   function automatic int seg_idx(input logic [6:0] p);
      seg_idx = -1;
      for (int k = 0; k < 10; k++) if (seg[k] == p) seg_idx = k;
   endfunction

   task automatic model_reset();
      m_cap = '0; m_cnt = 0; m_last = '0; m_last_vld = 0; m_prev = 0;
      exp_q.delete();
   endtask

   // kind: 0 = nothing, 1 = pattern error, 2 = conversion
   task automatic model_strobe(input logic [41:0] cap, output int kind, output logic wrap);
      int  d[6];
      bit  ok;
      int  sod;
      kind = 0;
      wrap = 1'b0;
      if (cap == m_cap) m_cnt = (m_cnt < S) ? m_cnt + 1 : S;
      else              m_cnt = 1;
      m_cap = cap;
      if (m_cnt != S || (m_last_vld && cap == m_last)) return;
      ok = 1;
      for (int i = 0; i < 6; i++) begin
         d[i] = seg_idx(cap[(5-i)*7 +: 7]);
         if (d[i] < 0) ok = 0;
      end
      if (ok) ok = (d[0] <= 2) && (d[0]*10 + d[1] <= 23) && (d[2] <= 5) && (d[4] <= 5);
      m_last = cap;
      m_last_vld = 1;
      if (!ok) begin
         kind = 1;
         return;
      end
      sod  = (d[0]*10 + d[1]) * 3600 + (d[2]*10 + d[3]) * 60 + d[4]*10 + d[5];
      wrap = (sod == 0) && (m_prev == 86399);
      m_prev = sod;
      kind = 2;
      exp_q.push_back(17'(sod));
   endtask

   // ---------------- driver tasks ----------------
   task automatic strobe(input logic [41:0] cap);
      @(negedge clk);
      {hh_in, hl_in, mh_in, ml_in, sh_in, sl_in} = cap;
      sample_en = 1'b1;
      @(negedge clk);
      sample_en = 1'b0;
   endtask

   // Strobe the same value n times, watching 8 cycles after each strobe.
   task automatic hold(input logic [41:0] cap, input int n);
      int   kind;
      logic w;
      e_err = 0; e_conv = 0; e_idx = -1; e_wrap = 1'b0;
      o_err = 0; o_vcnt = 0; o_vidx = -1; o_vcyc = -1; o_badwrap = 0;
      o_sod = '0; o_wrap = 1'b0; o_bcd = '0;
      for (int k = 0; k < n; k++) begin
         model_strobe(cap, kind, w);
         if (kind == 1) e_err++;
         if (kind == 2) begin e_conv++; e_idx = k; e_wrap = w; end
         strobe(cap);
         for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (pattern_err) o_err++;
            if (day_wrap && !sod_valid) o_badwrap++;
            if (sod_valid) begin
               if (o_vidx < 0) begin
                  o_vidx = k; o_vcyc = i; o_sod = sod_out; o_wrap = day_wrap;
`ifdef SSD_TIME_DEC_BCD_OUT_EN
                  o_bcd = bcd_out;
`endif
               end
               o_vcnt++;
            end
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      n_vec++; if (sod_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", sod_valid); end
      n_vec++; if (sod_out !== 17'd0) begin n_err++; $display("FAIL reset_sod: got %0d want 0", sod_out); end
      n_vec++; if (day_wrap !== 1'b0) begin n_err++; $display("FAIL reset_wrap: got %b want 0", day_wrap); end
      n_vec++; if (pattern_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", pattern_err); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      hold(pat(12, 34, 56), 2);
      n_vec++; if (o_vcnt !== 1) begin n_err++; $display("FAIL basic_vcnt: got %0d want 1", o_vcnt); end
      n_vec++; if (o_vidx !== 1) begin n_err++; $display("FAIL basic_strobe_idx: got %0d want 1", o_vidx); end
      n_vec++; if (o_vcyc !== 4) begin n_err++; $display("FAIL basic_latency: got %0d want 4", o_vcyc); end
      n_vec++; if (o_sod !== 17'd45296) begin n_err++; $display("FAIL basic_sod: got %0d want 45296", o_sod); end
      n_vec++; if (o_wrap !== 1'b0) begin n_err++; $display("FAIL basic_wrap: got %b want 0", o_wrap); end
      n_vec++; if (o_err !== 0) begin n_err++; $display("FAIL basic_err: got %0d want 0", o_err); end
`ifdef SSD_TIME_DEC_BCD_OUT_EN
      n_vec++; if (o_bcd !== 24'h123456) begin n_err++; $display("FAIL basic_bcd: got %h want 123456", o_bcd); end
`endif
      exp_q.delete();
   endtask

   task automatic test_day_wrap();
      hold(pat(23, 59, 59), 2);
      n_vec++; if (o_sod !== 17'd86399) begin n_err++; $display("FAIL wrap_max_sod: got %0d want 86399", o_sod); end
      n_vec++; if (o_wrap !== 1'b0) begin n_err++; $display("FAIL wrap_max_flag: got %b want 0", o_wrap); end
      hold(pat(0, 0, 0), 2);
      n_vec++; if (o_vcnt !== 1) begin n_err++; $display("FAIL wrap_zero_vcnt: got %0d want 1", o_vcnt); end
      n_vec++; if (o_sod !== 17'd0) begin n_err++; $display("FAIL wrap_zero_sod: got %0d want 0", o_sod); end
      n_vec++; if (o_wrap !== 1'b1) begin n_err++; $display("FAIL wrap_zero_flag: got %b want 1", o_wrap); end
      n_vec++; if (o_badwrap !== 0) begin n_err++; $display("FAIL wrap_outside_valid: got %0d want 0", o_badwrap); end
      hold(pat(0, 0, 1), 2);
      n_vec++; if (o_sod !== 17'd1) begin n_err++; $display("FAIL wrap_one_sod: got %0d want 1", o_sod); end
      n_vec++; if (o_wrap !== 1'b0) begin n_err++; $display("FAIL wrap_one_flag: got %b want 0", o_wrap); end
      exp_q.delete();
   endtask

   task automatic test_glitch();
      for (int i = 0; i < 6; i++) begin
         hold((i % 2 == 1) ? pat(10, 0, 0) : pat(10, 0, 1), 1);
         n_vec++; if (o_vcnt !== 0) begin n_err++; $display("FAIL glitch_no_valid[%0d]: got %0d want 0", i, o_vcnt); end
      end
      hold(pat(10, 0, 1), 2);
      n_vec++; if (o_vidx !== 1) begin n_err++; $display("FAIL glitch_strobe_idx: got %0d want 1", o_vidx); end
      n_vec++; if (o_sod !== 17'd36001) begin n_err++; $display("FAIL glitch_sod: got %0d want 36001", o_sod); end
      exp_q.delete();
   endtask

   task automatic test_bad_patterns();
      logic [41:0] bad [3];
      bad[0] = pat(24, 0, 0);
      bad[1] = {pat(12, 34, 50)} ; bad[1][13:7] = seg[6];
      bad[2] = pat(12, 34, 50);   bad[2][6:0]  = 7'd0;
      for (int c = 0; c < 3; c++) begin
         hold(bad[c], 2);
         n_vec++; if (o_err !== 1) begin n_err++; $display("FAIL bad%0d_pulses: got %0d want 1", c, o_err); end
         n_vec++; if (o_vcnt !== 0) begin n_err++; $display("FAIL bad%0d_valid: got %0d want 0", c, o_vcnt); end
         hold(bad[c], 3);
         n_vec++; if (o_err !== 0) begin n_err++; $display("FAIL bad%0d_repulse: got %0d want 0", c, o_err); end
      end
      exp_q.delete();
   endtask

   task automatic test_backpressure();
      int   kind;
      logic w;
      logic [41:0] c;
      c = pat(8, 15, 30);
      sod_ready = 1'b0;
      model_strobe(c, kind, w); strobe(c);
      model_strobe(c, kind, w); strobe(c);
      repeat (4) @(negedge clk);
      n_vec++; if (sod_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", sod_valid); end
      n_vec++; if (sod_out !== 17'd29730) begin n_err++; $display("FAIL bp_sod: got %0d want 29730", sod_out); end
      for (int i = 0; i < 10; i++) begin
         sample_en = 1'($urandom_range(0, 1));
         {hh_in, hl_in, mh_in, ml_in, sh_in, sl_in} = pat($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
         @(negedge clk);
         n_vec++; if (sod_valid !== 1'b1 || sod_out !== 17'd29730) begin
            n_err++; $display("FAIL bp_hold[%0d]: got valid=%b sod=%0d want valid=1 sod=29730", i, sod_valid, sod_out);
         end
      end
      sample_en = 1'b0;
      sod_ready = 1'b1;
      @(negedge clk);
      n_vec++; if (sod_valid !== 1'b0) begin n_err++; $display("FAIL bp_drop: got %b want 0", sod_valid); end
      exp_q.delete();
      hold(pat(8, 15, 31), 2);
      n_vec++; if (o_vidx !== 1 || o_sod !== 17'd29731) begin
         n_err++; $display("FAIL bp_next: got idx=%0d sod=%0d want idx=1 sod=29731", o_vidx, o_sod);
      end
      exp_q.delete();
   endtask

   task automatic test_random();
      logic [41:0] c;
      logic [16:0] esod;
      int          f;
      for (int it = 0; it < 40; it++) begin
         c = pat($urandom_range(0, 29), $urandom_range(0, 59), $urandom_range(0, 69));
         if ($urandom_range(0, 4) == 0) begin
            f = $urandom_range(0, 5);
            c[f*7 +: 7] = 7'($urandom_range(0, 127));
         end
         hold(c, $urandom_range(1, 3));
         n_vec++; if (o_err !== e_err) begin n_err++; $display("FAIL rnd%0d_err: got %0d want %0d", it, o_err, e_err); end
         n_vec++; if (o_vcnt !== e_conv) begin n_err++; $display("FAIL rnd%0d_vcnt: got %0d want %0d", it, o_vcnt, e_conv); end
         n_vec++; if (o_badwrap !== 0) begin n_err++; $display("FAIL rnd%0d_wrap_idle: got %0d want 0", it, o_badwrap); end
         if (e_conv == 1 && exp_q.size() > 0) begin
            esod = exp_q.pop_front();
            n_vec++; if (o_vidx !== e_idx || o_vcyc !== 4) begin
               n_err++; $display("FAIL rnd%0d_timing: got idx=%0d cyc=%0d want idx=%0d cyc=4", it, o_vidx, o_vcyc, e_idx);
            end
            n_vec++; if (o_sod !== esod) begin n_err++; $display("FAIL rnd%0d_sod: got %0d want %0d", it, o_sod, esod); end
            n_vec++; if (o_wrap !== e_wrap) begin n_err++; $display("FAIL rnd%0d_wrap: got %b want %b", it, o_wrap, e_wrap); end
         end
      end
      exp_q.delete();
   endtask

   task automatic test_reset_midway();
      int   kind;
      logic w;
      logic [41:0] c;
      hold(pat(23, 59, 59), 2);
      n_vec++; if (o_sod !== 17'd86399) begin n_err++; $display("FAIL mid_pre_sod: got %0d want 86399", o_sod); end
      c = pat(5, 6, 7);
      model_strobe(c, kind, w); strobe(c);
      model_strobe(c, kind, w); strobe(c);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_vec++; if (sod_valid !== 1'b0 || sod_out !== 17'd0 || day_wrap !== 1'b0 || pattern_err !== 1'b0) begin
         n_err++; $display("FAIL mid_reset_outputs: got valid=%b sod=%0d wrap=%b err=%b want all 0",
                           sod_valid, sod_out, day_wrap, pattern_err);
      end
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      hold(pat(0, 0, 0), 2);
      n_vec++; if (o_vcnt !== 1 || o_vidx !== 1) begin n_err++; $display("FAIL mid_after_valid: got cnt=%0d idx=%0d want 1/1", o_vcnt, o_vidx); end
      n_vec++; if (o_sod !== 17'd0) begin n_err++; $display("FAIL mid_after_sod: got %0d want 0", o_sod); end
      n_vec++; if (o_wrap !== 1'b0) begin n_err++; $display("FAIL mid_after_wrap: got %b want 0", o_wrap); end
      exp_q.delete();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic();
      test_day_wrap();
      test_glitch();
      test_bad_patterns();
      test_backpressure();
      test_random();
      test_reset_midway();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
